// File: rtl/memory_arbiter.sv
// Shares one single-port instruction/data memory between fetch and load/store.
// Sub-word stores use read-modify-write. MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module memory_arbiter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_resp_valid,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 d_req_valid,
    output logic                 d_req_ready,
    input  logic                 d_we,
    input  logic [1:0]           d_size,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_resp_valid,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_write_en,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_write_data,
    input  logic [WORD_SIZE-1:0] mem_data
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

    state_t               state;
    logic                 owner_d;
    logic [1:0]           size_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 grant_d;
    logic                 grant_f;
    logic                 accept_d;
    logic                 accept_f;
    logic [WORD_SIZE-1:0] merge;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;   // 1 = data won the last accept, 0 = fetch

    always_comb begin
        grant_d = d_req_valid;
        if (d_req_valid && if_req_valid)
            grant_d = !last_d;
        grant_f = if_req_valid && !grant_d;
    end
`else
    always_comb begin
        grant_d = d_req_valid;
        grant_f = if_req_valid && !d_req_valid;
    end
`endif

    assign d_req_ready  = (state == IDLE) && !rst && grant_d;
    assign if_req_ready = (state == IDLE) && !rst && grant_f;
    assign accept_d     = d_req_valid && d_req_ready;
    assign accept_f     = if_req_valid && if_req_ready;

    always_comb begin
        merge = mem_data;
        if (size_q == 2'b00)
            merge = {mem_data[WORD_SIZE-1:8], wdata_q[7:0]};
        else if (size_q == 2'b01)
            merge = {mem_data[WORD_SIZE-1:16], wdata_q[15:0]};
    end

    // mem_addr doubles as the latched request address for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            owner_d        <= 1'b0;
            size_q         <= '0;
            wdata_q        <= '0;
            if_resp_valid  <= 1'b0;
            if_rdata       <= '0;
            d_resp_valid   <= 1'b0;
            d_rdata        <= '0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d         <= 1'b0;
`endif
        end else begin
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_d) begin
                        owner_d  <= 1'b1;
                        mem_addr <= d_addr;
                        size_q   <= d_size;
                        wdata_q  <= d_wdata;
                        if (!d_we) begin
                            state <= RD;
                        end else if (d_size[1]) begin
                            state          <= WR;
                            mem_write_en   <= 1'b1;
                            mem_write_data <= d_wdata;
                        end else begin
                            state <= RMW_RD;
                        end
                    end else if (accept_f) begin
                        owner_d  <= 1'b0;
                        mem_addr <= if_addr;
                        state    <= RD;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (accept_d || accept_f)
                        last_d <= accept_d;
`endif
                end
                RD: begin
                    if (owner_d) begin
                        d_rdata      <= mem_data;
                        d_resp_valid <= 1'b1;
                    end else begin
                        if_rdata      <= mem_data;
                        if_resp_valid <= 1'b1;
                    end
                    mem_addr <= '0;
                    state    <= IDLE;
                end
                RMW_RD: begin
                    mem_write_en   <= 1'b1;
                    mem_write_data <= merge;
                    state          <= RMW_WR;
                end
                WR, RMW_WR: begin
                    d_rdata        <= '0;
                    d_resp_valid   <= 1'b1;
                    mem_write_en   <= 1'b0;
                    mem_write_data <= '0;
                    mem_addr       <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected responses queued at accept,
// checked for data and cycle when each response pulses.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_data;

    always #5 clk = ~clk;

    memory_arbiter #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_data(mem_data)
    );

    // Memory model with a backdoor write port for preloading.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk)
        if (mem_write_en) mem[mem_addr[7:2]] <= mem_write_data;
        else if (bd_we)   mem[bd_idx] <= bd_data;
    assign mem_data = mem[mem_addr[7:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t fq[$];
    exp_t dq[$];
    exp_t em;
    bit   glog[$];
    bit   cont = 1'b0;
    int   total = 0, bad = 0;
    int   last_if_cyc = -1;
    int   t, ft, dt, ta, tb2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if_resp_valid) begin
            last_if_cyc = cyc;
            if (fq.size() == 0) chk("if_spurious", 1, 0);
            else begin
                em = fq.pop_front();
                chk("if_rdata", if_rdata, em.data);
                chk("if_lat", cyc, em.cyc);
            end
        end
        if (d_resp_valid) begin
            if (dq.size() == 0) chk("d_spurious", 1, 0);
            else begin
                em = dq.pop_front();
                chk("d_rdata", d_rdata, em.data);
                chk("d_lat", cyc, em.cyc);
            end
        end
        if (cont && !rst) begin
            if (d_req_valid && d_req_ready) glog.push_back(1'b1);
            if (if_req_valid && if_req_ready) glog.push_back(1'b0);
`ifndef MEM_ARB_ROUND_ROBIN_EN
            if (if_req_valid && d_req_valid) chk("prio_if_ready", if_req_ready, 0);
`endif
        end
    end

    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic f_req(input logic [31:0] addr, output int tacc);
        int n;
        exp_t e;
        @(posedge clk); #1;
        if_addr = addr; if_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!if_req_ready && n < 50) begin @(negedge clk); n++; end
        if (!if_req_ready) begin
            chk("if_timeout", 0, 1);
            if_req_valid = 1'b0; tacc = -1;
            return;
        end
        tacc = cyc;
        e.data = ref_mem[addr[7:2]]; e.cyc = cyc + 2;
        fq.push_back(e);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
    endtask

    task automatic d_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int tacc);
        int n;
        exp_t e;
        logic [31:0] old;
        @(posedge clk); #1;
        d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!d_req_ready && n < 50) begin @(negedge clk); n++; end
        if (!d_req_ready) begin
            chk("d_timeout", 0, 1);
            d_req_valid = 1'b0; tacc = -1;
            return;
        end
        tacc = cyc;
        old  = ref_mem[addr[7:2]];
        if (!we) begin
            e.data = old; e.cyc = cyc + 2;
        end else begin
            e.data = 32'h0;
            e.cyc  = cyc + (size[1] ? 2 : 3);
            case (size)
                2'b00:   ref_mem[addr[7:2]] = {old[31:8], wdata[7:0]};
                2'b01:   ref_mem[addr[7:2]] = {old[31:16], wdata[15:0]};
                default: ref_mem[addr[7:2]] = wdata;
            endcase
        end
        dq.push_back(e);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        if_addr = 32'h0; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0; d_wdata = 32'h0;
        #12;
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_mwe", mem_write_en, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mwdata", mem_write_data, 0);
        chk("rst_resp", {if_resp_valid, d_resp_valid}, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;

        poke(6'd4, 32'hDEADBEEF);
        poke(6'd16, 32'hAABBCCDD);

        // fetch only
        f_req(32'h10, t);
        @(negedge clk);
        chk("f_maddr", mem_addr, 32'h10);
        chk("f_mwe", mem_write_en, 0);
        repeat (2) @(negedge clk);

        // word store then load
        d_req(1'b1, 2'b10, 32'h20, 32'h12345678, t);
        @(negedge clk);
        chk("ws_mwe", mem_write_en, 1);
        chk("ws_maddr", mem_addr, 32'h20);
        chk("ws_mwdata", mem_write_data, 32'h12345678);
        d_req(1'b0, 2'b10, 32'h20, 32'h0, t);

        // byte and halfword read-modify-write
        d_req(1'b1, 2'b00, 32'h40, 32'h000000EE, t);
        @(negedge clk);
        chk("rmwb_rd_mwe", mem_write_en, 0);
        chk("rmwb_rd_maddr", mem_addr, 32'h40);
        @(negedge clk);
        chk("rmwb_wr_mwe", mem_write_en, 1);
        chk("rmwb_wr_data", mem_write_data, 32'hAABBCCEE);
        d_req(1'b1, 2'b01, 32'h40, 32'h00001122, t);
        @(negedge clk);
        @(negedge clk);
        chk("rmwh_wr_mwe", mem_write_en, 1);
        chk("rmwh_wr_data", mem_write_data, 32'hAABB1122);
        d_req(1'b0, 2'b10, 32'h40, 32'h0, t);

        // fetch response coincides with next data accept
        f_req(32'h20, ft);
        d_req(1'b0, 2'b10, 32'h10, 32'h0, dt);
        chk("b2b_accept", dt, ft + 2);
        chk("b2b_same_cycle", last_if_cyc, dt);
        repeat (4) @(negedge clk);

        // reset during RMW_RD aborts the write and the response
        poke(6'd16, 32'hAABBCCDD);
        d_req(1'b1, 2'b00, 32'h40, 32'h00000055, t);
        rst = 1'b1;
        dq.delete();
        ref_mem[16] = 32'hAABBCCDD;
        d_req_valid = 1'b1;
        #1;
        chk("mrst_mwe", mem_write_en, 0);
        chk("mrst_maddr", mem_addr, 0);
        chk("mrst_d_ready", d_req_ready, 0);
        d_req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_mem", mem[16], 32'hAABBCCDD);
        d_req(1'b0, 2'b10, 32'h40, 32'h0, t);
        repeat (3) @(negedge clk);

        // contention
        glog.delete();
        cont = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        fork
            begin repeat (2) d_req(1'b0, 2'b10, 32'h20, 32'h0, ta); end
            begin repeat (2) f_req(32'h10, tb2); end
        join
        cont = 1'b0;
        chk("rr_count", glog.size(), 4);
        for (int i = 1; i < glog.size(); i++)
            chk("rr_alternate", {31'b0, glog[i]}, {31'b0, ~glog[i-1]});
`else
        fork
            begin repeat (4) d_req(1'b0, 2'b10, 32'h20, 32'h0, ta); end
            begin f_req(32'h10, tb2); end
        join
        cont = 1'b0;
        chk("prio_count", glog.size(), 5);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk("prio_data_first", {31'b0, glog[i]}, 1);
`endif

        repeat (6) @(negedge clk);
        chk("fq_drained", fq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        chk("mem_10", mem[4], ref_mem[4]);
        chk("mem_20", mem[8], ref_mem[8]);
        chk("mem_40", mem[16], ref_mem[16]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
